// File: rtl/idex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Detects load-use hazards, inserts bubbles, and counts them saturating.
module idex_stage #(
  parameter int unsigned BUBBLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic                regwriteD,
  input  logic                regdstD,
  input  logic                alusrcD,
  input  logic                branchD,
  input  logic                bneD,
  input  logic                memwriteD,
  input  logic                memtoregD,
  input  logic                jumpD,
  input  logic [1:0]          aluopD,
  input  logic [31:0]         rd1D,
  input  logic [31:0]         rd2D,
  input  logic [31:0]         signimmD,
  input  logic [31:0]         pcplus4D,
  input  logic [4:0]          rsD,
  input  logic [4:0]          rtD,
  input  logic [4:0]          rdD,
  input  logic                flushE,
  input  logic                holdE,
  output logic                regwriteE,
  output logic                regdstE,
  output logic                alusrcE,
  output logic                branchE,
  output logic                bneE,
  output logic                memwriteE,
  output logic                memtoregE,
  output logic                jumpE,
  output logic [1:0]          aluopE,
  output logic [31:0]         rd1E,
  output logic [31:0]         rd2E,
  output logic [31:0]         signimmE,
  output logic [31:0]         pcplus4E,
  output logic [4:0]          rsE,
  output logic [4:0]          rtE,
  output logic [4:0]          writeregE,
  output logic                validE,
  output logic                stallD,
  output logic [BUBBLE_W-1:0] bubblecnt
);

  logic       hazard;
  logic       kill;
  logic [4:0] writeregD;

  assign writeregD = regdstD ? rdD : rtD;

  always_comb begin
    hazard = validE & memtoregE & regwriteE & (writeregE != 5'd0) & validD &
             ((writeregE == rsD) | (writeregE == rtD));
    kill   = flushE | hazard;
  end

  assign stallD = hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      validE    <= 1'b0;
      regwriteE <= 1'b0;
      regdstE   <= 1'b0;
      alusrcE   <= 1'b0;
      branchE   <= 1'b0;
      bneE      <= 1'b0;
      memwriteE <= 1'b0;
      memtoregE <= 1'b0;
      jumpE     <= 1'b0;
      aluopE    <= 2'b00;
      rd1E      <= 32'd0;
      rd2E      <= 32'd0;
      signimmE  <= 32'd0;
      pcplus4E  <= 32'd0;
      rsE       <= 5'd0;
      rtE       <= 5'd0;
      writeregE <= 5'd0;
      bubblecnt <= '0;
    end else if (!holdE) begin
      // Data and non-side-effecting controls load even when killed; they are
      // ignored while validE is low.
      regdstE   <= validD & regdstD;
      alusrcE   <= validD & alusrcD;
      aluopE    <= validD ? aluopD : 2'b00;
      rd1E      <= rd1D;
      rd2E      <= rd2D;
      signimmE  <= signimmD;
      pcplus4E  <= pcplus4D;
      rsE       <= rsD;
      rtE       <= rtD;
      writeregE <= writeregD;
      if (kill) begin
        validE    <= 1'b0;
        regwriteE <= 1'b0;
        branchE   <= 1'b0;
        bneE      <= 1'b0;
        memwriteE <= 1'b0;
        memtoregE <= 1'b0;
        jumpE     <= 1'b0;
      end else begin
        validE    <= validD;
        regwriteE <= validD & regwriteD & (writeregD != 5'd0);
        branchE   <= validD & branchD;
        bneE      <= validD & bneD;
        memwriteE <= validD & memwriteD;
        memtoregE <= validD & memtoregD;
        jumpE     <= validD & jumpD;
      end
      // A flush takes precedence over a bubble, so it is not counted.
      if (hazard && !flushE && (bubblecnt != {BUBBLE_W{1'b1}})) begin
        bubblecnt <= bubblecnt + BUBBLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed scenarios then random traffic,
// compared against a transaction-level model of the E slot.
module tb_idex_stage;

  typedef struct packed {
    logic        v, rw, rdst, asrc, br, bne, mw, m2r, j;
    logic [1:0]  aop;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } d_t;

  typedef struct packed {
    logic        v, rw, rdst, asrc, br, bne, mw, m2r, j;
    logic [1:0]  aop;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, wr;
  } e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        validD, regwriteD, regdstD, alusrcD, branchD, bneD, memwriteD, memtoregD, jumpD;
  logic [1:0]  aluopD;
  logic [31:0] rd1D, rd2D, signimmD, pcplus4D;
  logic [4:0]  rsD, rtD, rdD;
  logic        flushE, holdE;
  logic        regwriteE, regdstE, alusrcE, branchE, bneE, memwriteE, memtoregE, jumpE;
  logic [1:0]  aluopE;
  logic [31:0] rd1E, rd2E, signimmE, pcplus4E;
  logic [4:0]  rsE, rtE, writeregE;
  logic        validE, stallD;
  logic [15:0] bubblecnt;

  // Narrow-counter instance sharing all inputs, to reach saturation quickly.
  logic        s_regwriteE, s_regdstE, s_alusrcE, s_branchE, s_bneE, s_memwriteE;
  logic        s_memtoregE, s_jumpE, s_validE, s_stallD;
  logic [1:0]  s_aluopE;
  logic [31:0] s_rd1E, s_rd2E, s_signimmE, s_pcplus4E;
  logic [4:0]  s_rsE, s_rtE, s_writeregE;
  logic [2:0]  s_bubblecnt;

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .reset(reset), .validD(validD), .regwriteD(regwriteD), .regdstD(regdstD),
    .alusrcD(alusrcD), .branchD(branchD), .bneD(bneD), .memwriteD(memwriteD),
    .memtoregD(memtoregD), .jumpD(jumpD), .aluopD(aluopD), .rd1D(rd1D), .rd2D(rd2D),
    .signimmD(signimmD), .pcplus4D(pcplus4D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .flushE(flushE), .holdE(holdE), .regwriteE(regwriteE), .regdstE(regdstE),
    .alusrcE(alusrcE), .branchE(branchE), .bneE(bneE), .memwriteE(memwriteE),
    .memtoregE(memtoregE), .jumpE(jumpE), .aluopE(aluopE), .rd1E(rd1E), .rd2E(rd2E),
    .signimmE(signimmE), .pcplus4E(pcplus4E), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .validE(validE), .stallD(stallD), .bubblecnt(bubblecnt)
  );

  idex_stage #(.BUBBLE_W(3)) dut_small (
    .clk(clk), .reset(reset), .validD(validD), .regwriteD(regwriteD), .regdstD(regdstD),
    .alusrcD(alusrcD), .branchD(branchD), .bneD(bneD), .memwriteD(memwriteD),
    .memtoregD(memtoregD), .jumpD(jumpD), .aluopD(aluopD), .rd1D(rd1D), .rd2D(rd2D),
    .signimmD(signimmD), .pcplus4D(pcplus4D), .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .flushE(flushE), .holdE(holdE), .regwriteE(s_regwriteE), .regdstE(s_regdstE),
    .alusrcE(s_alusrcE), .branchE(s_branchE), .bneE(s_bneE), .memwriteE(s_memwriteE),
    .memtoregE(s_memtoregE), .jumpE(s_jumpE), .aluopE(s_aluopE), .rd1E(s_rd1E),
    .rd2E(s_rd2E), .signimmE(s_signimmE), .pcplus4E(s_pcplus4E), .rsE(s_rsE),
    .rtE(s_rtE), .writeregE(s_writeregE), .validE(s_validE), .stallD(s_stallD),
    .bubblecnt(s_bubblecnt)
  );

  int   checks = 0;
  int   errors = 0;
  e_t   me;          // model of the E slot
  bit   known;       // non-kill fields of me are meaningful
  int   cnt;         // bubbles inserted since reset (unbounded)
  logic last_stall;  // stallD sampled before the most recent edge

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] e_vec();
    return {regwriteE, regdstE, alusrcE, branchE, bneE, memwriteE, memtoregE, jumpE, aluopE,
            rd1E, rd2E, signimmE, pcplus4E, rsE, rtE, writeregE, validE, bubblecnt};
  endfunction

  function automatic bit m_hazard(input e_t e, input d_t d);
    return e.v && e.m2r && e.rw && (e.wr != 0) && d.v && (e.wr == d.rs || e.wr == d.rt);
  endfunction

  function automatic d_t rnd_d();
    d_t d;
    d.v    = ($urandom % 8) != 0;
    d.rw   = ($urandom % 4) != 0;
    d.rdst = 1'($urandom);
    d.asrc = 1'($urandom);
    d.br   = ($urandom % 6) == 0;
    d.bne  = ($urandom % 6) == 0;
    d.mw   = ($urandom % 5) == 0;
    d.m2r  = 1'($urandom);
    d.j    = ($urandom % 8) == 0;
    d.aop  = 2'($urandom);
    d.rd1  = $urandom;
    d.rd2  = $urandom;
    d.imm  = $urandom;
    d.pc4  = $urandom;
    d.rs   = 5'($urandom_range(0, 3));
    d.rt   = 5'($urandom_range(0, 3));
    d.rd   = 5'($urandom_range(0, 3));
    return d;
  endfunction

  task automatic drive(input d_t d, input bit rst, input bit hold, input bit flush);
    reset = rst; holdE = hold; flushE = flush;
    validD = d.v; regwriteD = d.rw; regdstD = d.rdst; alusrcD = d.asrc; branchD = d.br;
    bneD = d.bne; memwriteD = d.mw; memtoregD = d.m2r; jumpD = d.j; aluopD = d.aop;
    rd1D = d.rd1; rd2D = d.rd2; signimmD = d.imm; pcplus4D = d.pc4;
    rsD = d.rs; rtD = d.rt; rdD = d.rd;
  endtask

  task automatic check_e();
    int sat16, sat3;
    sat16 = (cnt > 65535) ? 65535 : cnt;
    sat3  = (cnt > 7) ? 7 : cnt;
    chk("validE", validE, me.v);
    chk("regwriteE", regwriteE, me.rw);
    chk("memwriteE", memwriteE, me.mw);
    chk("memtoregE", memtoregE, me.m2r);
    chk("branchE", branchE, me.br);
    chk("bneE", bneE, me.bne);
    chk("jumpE", jumpE, me.j);
    chk("bubblecnt", bubblecnt, sat16);
    chk("bubblecnt_small", s_bubblecnt, sat3);
    if (known) begin
      chk("ctrl_misc", {regdstE, alusrcE, aluopE}, {me.rdst, me.asrc, me.aop});
      chk("data", {rd1E, rd2E, signimmE, pcplus4E}, {me.rd1, me.rd2, me.imm, me.pc4});
      chk("regs", {rsE, rtE, writeregE}, {me.rs, me.rt, me.wr});
    end
  endtask

  // One clock: drive D, check stallD, clock, advance the model, check E.
  task automatic step(input d_t d, input bit rst, input bit hold, input bit flush);
    bit   hz;
    logic [4:0] dest;
    drive(d, rst, hold, flush);
    #1;
    hz = m_hazard(me, d);
    last_stall = stallD;
    chk("stallD", stallD, hz);
    @(posedge clk);
    if (rst) begin
      me = '0; known = 1'b1; cnt = 0;
    end else if (!hold) begin
      if (flush || hz) begin
        me.v = 0; me.rw = 0; me.mw = 0; me.m2r = 0; me.br = 0; me.bne = 0; me.j = 0;
        known = 1'b0;
        if (!flush) cnt++;
      end else begin
        dest   = d.rdst ? d.rd : d.rt;
        me.v   = d.v;
        me.rw  = d.v && d.rw && dest != 0;
        me.rdst = d.v && d.rdst;  me.asrc = d.v && d.asrc;
        me.br  = d.v && d.br;     me.bne = d.v && d.bne;
        me.mw  = d.v && d.mw;     me.m2r = d.v && d.m2r;
        me.j   = d.v && d.j;      me.aop = d.v ? d.aop : 2'b00;
        me.rd1 = d.rd1; me.rd2 = d.rd2; me.imm = d.imm; me.pc4 = d.pc4;
        me.rs  = d.rs;  me.rt = d.rt;   me.wr = dest;
        known  = 1'b1;
      end
    end
    #1;
    check_e();
  endtask

  function automatic d_t mk_lw(input logic [4:0] rt);
    d_t d = '0;
    d.v = 1; d.rw = 1; d.m2r = 1; d.asrc = 1; d.rs = 5'd29; d.rt = rt; d.imm = 32'h10;
    return d;
  endfunction

  function automatic d_t mk_add(input logic [4:0] rs, input logic [4:0] rt);
    d_t d = '0;
    d.v = 1; d.rw = 1; d.rdst = 1; d.aop = 2'b10; d.rs = rs; d.rt = rt; d.rd = 5'd10;
    d.rd1 = 32'h1234; d.rd2 = 32'h5678;
    return d;
  endfunction

  initial begin
    d_t d;
    logic [255:0] snap;
    int b0;
    me = '0; known = 1'b1; cnt = 0;
    drive(rnd_d(), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset with random D inputs
    step(rnd_d(), 1, 0, 0);
    step(rnd_d(), 1, 0, 0);
    chk("reset_all", e_vec(), 256'd0);

    // addi $t0, $s0, 5
    d = '0; d.v = 1; d.rw = 1; d.asrc = 1; d.rs = 5'd16; d.rt = 5'd8; d.imm = 32'd5;
    step(d, 0, 0, 0);
    chk("reset_stall", last_stall, 1'b0);
    chk("addi", {writeregE, regwriteE, alusrcE, aluopE, validE}, {5'd8, 1'b1, 1'b1, 2'b00, 1'b1});

    // Load-use: one bubble, then the add issues
    step(mk_lw(5'd8), 0, 0, 0);
    step(mk_add(5'd8, 5'd9), 0, 0, 0);
    chk("lu_stall", last_stall, 1'b1);
    chk("lu_bubble", {validE, bubblecnt}, {1'b0, 16'd1});
    step(mk_add(5'd8, 5'd9), 0, 0, 0);
    chk("lu_stall_drop", last_stall, 1'b0);
    chk("lu_issue", {validE, rsE}, {1'b1, 5'd8});

    // Zero destination never stalls
    step(mk_lw(5'd0), 0, 0, 0);
    chk("zero_rw", regwriteE, 1'b0);
    step(mk_add(5'd0, 5'd9), 0, 0, 0);
    chk("zero_stall", last_stall, 1'b0);

    // Flush coinciding with a hazard
    step(mk_lw(5'd8), 0, 0, 0);
    b0 = bubblecnt;
    step(mk_add(5'd9, 5'd8), 0, 0, 1);
    chk("flush_stall", last_stall, 1'b1);
    chk("flush_kill", {validE, bubblecnt}, {1'b0, 16'(b0)});

    // Hold during a hazard freezes E, then the bubble lands
    step(mk_lw(5'd8), 0, 0, 0);
    snap = e_vec();
    for (int i = 0; i < 3; i++) begin
      step(mk_add(5'd8, 5'd9), 0, 1, 0);
      chk("hold_stall", last_stall, 1'b1);
      chk("hold_freeze", e_vec(), snap);
    end
    step(mk_add(5'd8, 5'd9), 0, 0, 0);
    chk("hold_release", {validE, bubblecnt}, {1'b0, 16'(b0 + 1)});

    // Reset mid-hazard
    step(mk_lw(5'd8), 0, 0, 0);
    step(mk_add(5'd8, 5'd9), 1, 0, 0);
    step(mk_add(5'd8, 5'd9), 0, 0, 0);
    chk("reset_mid_hz", last_stall, 1'b0);

    // Drive the narrow counter into saturation
    for (int i = 0; i < 10; i++) begin
      step(mk_lw(5'd3), 0, 0, 0);
      step(mk_add(5'd3, 5'd1), 0, 0, 0);
    end
    chk("sat_small", s_bubblecnt, 3'd7);
    chk("count_wide", bubblecnt, 16'd10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(rnd_d(), ($urandom % 97) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline stage for the pipelined MIPS core: registers the main-decoder control word plus decode-stage operands into the execute stage. Detects load-use hazards, inserting a bubble and stalling fetch/decode. Honours branch/jump flush and a global downstream hold. Keeps a saturating count of inserted bubbles for performance monitoring.

## Interface
- `BUBBLE_W`, 16, width of the saturating bubble counter.
- `clk`  in  1  rising-edge clock, sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `validD`  in  1  decode slot holds a real instruction.
- `regwriteD, regdstD, alusrcD, branchD, bneD, memwriteD, memtoregD, jumpD`  in  1 each  decoded control bits.
- `aluopD`  in  2  decoded ALU op class.
- `rd1D, rd2D`  in  32  register-file read data.
- `signimmD, pcplus4D`  in  32  sign-extended immediate; PC+4.
- `rsD, rtD, rdD`  in  5  register specifiers.
- `flushE`  in  1  branch/jump taken: kill the instruction entering E.
- `holdE`  in  1  downstream stall: freeze E contents.
- `regwriteE … jumpE, aluopE, rd1E, rd2E, signimmE, pcplus4E, rsE, rtE`  out  same widths  registered copies.
- `writeregE`  out  5  destination: `rdD` if `regdstD`, else `rtD`, registered.
- `validE`  out  1  E slot holds a real instruction.
- `stallD`  out  1  combinational; freeze PC and IF/ID this cycle.
- `bubblecnt`  out  `BUBBLE_W`  saturating count of load-use bubbles.

## Operation
- Per-cycle update priority, highest first: `reset` > `holdE` > `flushE` > load-use bubble > normal load.
- Reset: every registered output is 0: all control bits, `aluopE`=00, data/specifier fields, `writeregE`, `validE`, `bubblecnt`.
- Hold: all E registers and `bubblecnt` keep their values.
- Flush or bubble: `validE`, `regwriteE`, `memwriteE`, `memtoregE`, `branchE`, `bneE` and `jumpE` become 0. Data fields may load or hold; they are don't-care while `validE`=0.
- Normal load: all fields are copied from the D inputs and `validE` becomes `validD`.
- Zero-register rule: if the computed destination is 0, `regwriteE` loads 0 even when `regwriteD`=1.
- If `validD`=0 on a normal load, all control bits load as 0.
- Load-use hazard: `validE & memtoregE & regwriteE & (writeregE != 0) & validD & (writeregE == rsD | writeregE == rtD)`.
- `stallD` equals the hazard term, independent of `flushE` and `holdE`. Upstream combines `stallD` with `holdE`.
- Bubble counter increments by 1 on each clock where a bubble is inserted: hazard true, `holdE`=0, `flushE`=0.
- The counter saturates at all-ones and never wraps.
- A flush that coincides with a hazard counts as a flush, not a bubble.

## Timing
- Latency is 1 cycle: D inputs sampled at edge N appear on E outputs after edge N.
- `stallD` is purely combinational from current E state and D inputs; there is no register on this path.
- Load-use costs exactly one bubble. After the bubble, `memtoregE`=0, so `stallD` drops the next cycle and the stalled instruction loads.
- Reset asserted mid-hazard: `stallD` is 0 in the cycle after the reset edge, because `validE`=0.
- `holdE` asserted during a hazard: E freezes and `stallD` stays 1 until `holdE` releases. The bubble is then inserted on the first non-held edge.

## Test plan
- Reset: drive `reset`=1 for 2 cycles with random D inputs -> every output 0, `bubblecnt`=0, `stallD`=0.
- Pass-through, addi $t0 = $s0+5: `regwriteD`=1, `alusrcD`=1, `rtD`=8, `regdstD`=0, `signimmD`=5. Next cycle -> `writeregE`=8, `regwriteE`=1, `alusrcE`=1, `aluopE`=00, `validE`=1.
- Load-use: lw $t0 in E (`memtoregE`=1, `writeregE`=8), then add with `rsD`=8.
  - Required: `stallD`=1 that cycle.
  - Next cycle: `validE`=0, `bubblecnt`=1, `stallD`=0.
  - Following cycle: the add is in E with `rsE`=8.
- Zero destination: lw with `rtD`=0 -> `regwriteE`=0. A following add with `rsD`=0 -> `stallD`=0.
- Flush vs. hazard: hazard active and `flushE`=1 in the same cycle -> `validE`=0 next cycle, `bubblecnt` unchanged.
- Hold and saturation:
  - `holdE`=1 for 3 cycles -> all E outputs are stable across those cycles.
  - Preload `bubblecnt` to 16'hFFFF and force another bubble -> count remains 16'hFFFF.
